// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side input bundle, execute-side registered
// bundle, writeback bypass port, flush and load-use hazard report.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12,
    parameter int RA_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_rd1;
    logic [XLEN-1:0]   in_rd2;
    logic [XLEN-1:0]   in_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic [RA_W-1:0]   in_rs1;
    logic [RA_W-1:0]   in_rs2;
    logic [RA_W-1:0]   in_rd;
    logic              in_mem_read;

    logic              wb_we;
    logic [RA_W-1:0]   wb_rd;
    logic [XLEN-1:0]   wb_data;

    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_rd1;
    logic [XLEN-1:0]   out_rd2;
    logic [XLEN-1:0]   out_imm;
    logic [CTRL_W-1:0] out_ctrl;
    logic [RA_W-1:0]   out_rs1;
    logic [RA_W-1:0]   out_rs2;
    logic [RA_W-1:0]   out_rd;
    logic              out_mem_read;

    logic              hazard_stall;

    modport slave (
        input  in_valid, in_pc, in_rd1, in_rd2, in_imm, in_ctrl,
        input  in_rs1, in_rs2, in_rd, in_mem_read,
        input  wb_we, wb_rd, wb_data, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rd1, out_rd2,
        output out_imm, out_ctrl, out_rs1, out_rs2, out_rd,
        output out_mem_read, hazard_stall
    );

    modport master (
        output in_valid, in_pc, in_rd1, in_rd2, in_imm, in_ctrl,
        output in_rs1, in_rs2, in_rd, in_mem_read,
        output wb_we, wb_rd, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rd1, out_rd2,
        input  out_imm, out_ctrl, out_rs1, out_rs2, out_rd,
        input  out_mem_read, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-slot valid/ready stage with load-use
// hazard detection and writeback bypass on capture and while holding.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12,
    parameter int RA_W   = 5
) (
    input logic           clk,
    input logic           rst,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic              mem_read;
    } slot_t;

    slot_t slot;
    logic  valid;

    logic  hazard;
    logic  ready;
    logic  accept;
    logic  drain;
    logic  wb_ok;
    logic  hit_in1;
    logic  hit_in2;
    logic  hit_hold1;
    logic  hit_hold2;
    logic  src_hit;
    slot_t nxt_in;

    always_comb begin
        src_hit = (slot.rd == bus.in_rs1) || (slot.rd == bus.in_rs2);
        hazard  = bus.in_valid && valid && slot.mem_read &&
                  (slot.rd != '0) && src_hit;
        ready   = (!valid || bus.out_ready) && !hazard && !bus.flush;
        accept  = bus.in_valid && ready;
        drain   = valid && bus.out_ready;
    end

    // x0 is hardwired; a write to it must never be forwarded
    always_comb begin
        wb_ok     = bus.wb_we && (bus.wb_rd != '0);
        hit_in1   = wb_ok && (bus.wb_rd == bus.in_rs1);
        hit_in2   = wb_ok && (bus.wb_rd == bus.in_rs2);
        hit_hold1 = wb_ok && (bus.wb_rd == slot.rs1);
        hit_hold2 = wb_ok && (bus.wb_rd == slot.rs2);
    end

    always_comb begin
        nxt_in.pc       = bus.in_pc;
        nxt_in.rd1      = hit_in1 ? bus.wb_data : bus.in_rd1;
        nxt_in.rd2      = hit_in2 ? bus.wb_data : bus.in_rd2;
        nxt_in.imm      = bus.in_imm;
        nxt_in.ctrl     = bus.in_ctrl;
        nxt_in.rs1      = bus.in_rs1;
        nxt_in.rs2      = bus.in_rs2;
        nxt_in.rd       = bus.in_rd;
        nxt_in.mem_read = bus.in_mem_read;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            slot  <= '0;
        end else if (bus.flush) begin
            valid <= 1'b0;
        end else if (accept) begin
            valid <= 1'b1;
            slot  <= nxt_in;
        end else if (drain) begin
            valid <= 1'b0;
        end else if (valid) begin
            // a held operand must not go stale behind a later writeback
            if (hit_hold1) slot.rd1 <= bus.wb_data;
            if (hit_hold2) slot.rd2 <= bus.wb_data;
        end
    end

    assign bus.in_ready     = ready;
    assign bus.hazard_stall = hazard;
    assign bus.out_valid    = valid;
    assign bus.out_pc       = slot.pc;
    assign bus.out_rd1      = slot.rd1;
    assign bus.out_rd2      = slot.rd2;
    assign bus.out_imm      = slot.imm;
    assign bus.out_ctrl     = slot.ctrl;
    assign bus.out_rs1      = slot.rs1;
    assign bus.out_rs2      = slot.rs2;
    assign bus.out_rd       = slot.rd;
    assign bus.out_mem_read = slot.mem_read;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic,
// all checked against a bundle-level reference model.
module tb_id_ex_stage;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 12;
    localparam int RA_W   = 5;

    logic clk;
    logic rst;

    id_ex_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RA_W(RA_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RA_W(RA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit               valid;
        bit [XLEN-1:0]    pc;
        bit [XLEN-1:0]    rd1;
        bit [XLEN-1:0]    rd2;
        bit [XLEN-1:0]    imm;
        bit [CTRL_W-1:0]  ctrl;
        bit [RA_W-1:0]    rs1;
        bit [RA_W-1:0]    rs2;
        bit [RA_W-1:0]    rd;
        bit               mem_read;
        bit               wb_we;
        bit [RA_W-1:0]    wb_rd;
        bit [XLEN-1:0]    wb_data;
        bit               flush;
        bit               out_ready;
    } stim_t;

    typedef struct {
        bit               valid;
        bit [XLEN-1:0]    pc;
        bit [XLEN-1:0]    rd1;
        bit [XLEN-1:0]    rd2;
        bit [XLEN-1:0]    imm;
        bit [CTRL_W-1:0]  ctrl;
        bit [RA_W-1:0]    rs1;
        bit [RA_W-1:0]    rs2;
        bit [RA_W-1:0]    rd;
        bit               mem_read;
    } bundle_t;

    bundle_t m;
    int n_chk;
    int n_pass;
    int n_fail;
    logic obs_haz;
    logic obs_rdy;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.out_ready = 1'b1;
        return s;
    endfunction

    function automatic bit fwd(stim_t s, bit [RA_W-1:0] ra);
        return s.wb_we && s.wb_rd != 0 && s.wb_rd == ra;
    endfunction

    task automatic apply(input stim_t s);
        bus.in_valid    = s.valid;
        bus.in_pc       = s.pc;
        bus.in_rd1      = s.rd1;
        bus.in_rd2      = s.rd2;
        bus.in_imm      = s.imm;
        bus.in_ctrl     = s.ctrl;
        bus.in_rs1      = s.rs1;
        bus.in_rs2      = s.rs2;
        bus.in_rd       = s.rd;
        bus.in_mem_read = s.mem_read;
        bus.wb_we       = s.wb_we;
        bus.wb_rd       = s.wb_rd;
        bus.wb_data     = s.wb_data;
        bus.flush       = s.flush;
        bus.out_ready   = s.out_ready;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, bus.out_valid, m.valid);
        if (m.valid) begin
            chk({tag, ".pc"},  bus.out_pc,  m.pc);
            chk({tag, ".rd1"}, bus.out_rd1, m.rd1);
            chk({tag, ".rd2"}, bus.out_rd2, m.rd2);
            chk({tag, ".imm"}, bus.out_imm, m.imm);
            chk({tag, ".ctrl"}, bus.out_ctrl, m.ctrl);
            chk({tag, ".rs"}, {bus.out_rs1, bus.out_rs2, bus.out_rd},
                {m.rs1, m.rs2, m.rd});
            chk({tag, ".mr"}, bus.out_mem_read, m.mem_read);
        end
    endtask

    // One cycle: drive after falling edge, check handshake, advance model
    task automatic step(input stim_t s, input string tag);
        bit haz;
        bit rdy;
        @(negedge clk);
        apply(s);
        #1;
        haz = s.valid && m.valid && m.mem_read && m.rd != 0 &&
              (m.rd == s.rs1 || m.rd == s.rs2);
        rdy = (!m.valid || s.out_ready) && !haz && !s.flush;
        obs_haz = bus.hazard_stall;
        obs_rdy = bus.in_ready;
        chk({tag, ".haz"}, obs_haz, haz);
        chk({tag, ".rdy"}, obs_rdy, rdy);
        if (s.flush) begin
            m.valid = 0;
        end else if (s.valid && rdy) begin
            m.valid    = 1;
            m.pc       = s.pc;
            m.rd1      = fwd(s, s.rs1) ? s.wb_data : s.rd1;
            m.rd2      = fwd(s, s.rs2) ? s.wb_data : s.rd2;
            m.imm      = s.imm;
            m.ctrl     = s.ctrl;
            m.rs1      = s.rs1;
            m.rs2      = s.rs2;
            m.rd       = s.rd;
            m.mem_read = s.mem_read;
        end else if (m.valid && s.out_ready) begin
            m.valid = 0;
        end else if (m.valid) begin
            if (fwd(s, m.rs1)) m.rd1 = s.wb_data;
            if (fwd(s, m.rs2)) m.rd2 = s.wb_data;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Reset pulse strictly between clock edges
    task automatic async_rst(input string tag);
        @(negedge clk);
        apply(idle());
        #2;
        rst = 1'b1;
        #1;
        chk({tag, ".valid"}, bus.out_valid, 0);
        chk({tag, ".pc"}, bus.out_pc, 0);
        chk({tag, ".mr"}, bus.out_mem_read, 0);
        #1;
        rst = 1'b0;
        m = '{default: '0};
    endtask

    function automatic stim_t rnd();
        stim_t s;
        s.valid     = ($urandom_range(0, 3) != 0);
        s.pc        = $urandom;
        s.rd1       = $urandom;
        s.rd2       = $urandom;
        s.imm       = $urandom;
        s.ctrl      = CTRL_W'($urandom);
        s.rs1       = RA_W'($urandom_range(0, 7));
        s.rs2       = RA_W'($urandom_range(0, 7));
        s.rd        = RA_W'($urandom_range(0, 7));
        s.mem_read  = ($urandom_range(0, 2) == 0);
        s.wb_we     = ($urandom_range(0, 1) == 0);
        s.wb_rd     = RA_W'($urandom_range(0, 7));
        s.wb_data   = $urandom;
        s.flush     = ($urandom_range(0, 19) == 0);
        s.out_ready = ($urandom_range(0, 3) != 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        m = '{default: '0};
        rst = 1'b1;
        apply(idle());
        #3;
        chk("rst.valid", bus.out_valid, 0);
        chk("rst.pc", bus.out_pc, 0);
        chk("rst.rd1", bus.out_rd1, 0);
        chk("rst.mr", bus.out_mem_read, 0);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back at full throughput
        for (int i = 0; i < 4; i++) begin
            s = idle();
            s.valid = 1;
            s.pc = 32'(i * 4);
            s.rs1 = 1;
            s.rs2 = 2;
            step(s, "b2b");
            chk("b2b.out_pc", bus.out_pc, 64'(i * 4));
            chk("b2b.out_valid", bus.out_valid, 1);
        end

        // backpressure
        s = idle();
        s.valid = 1;
        s.pc = 32'h10;
        step(s, "bp.load");
        for (int i = 0; i < 3; i++) begin
            s = idle();
            s.valid = 1;
            s.pc = 32'h14;
            s.out_ready = 0;
            step(s, "bp.hold");
            chk("bp.in_ready", obs_rdy, 0);
            chk("bp.out_pc", bus.out_pc, 32'h10);
        end
        s.out_ready = 1;
        step(s, "bp.go");
        chk("bp.next_pc", bus.out_pc, 32'h14);

        // load-use: one bubble then accept
        s = idle();
        s.valid = 1;
        s.pc = 32'h20;
        s.mem_read = 1;
        s.rd = 5;
        step(s, "lu.load");
        s = idle();
        s.valid = 1;
        s.pc = 32'h24;
        s.rs2 = 5;
        step(s, "lu.use");
        chk("lu.stall", obs_haz, 1);
        chk("lu.in_ready", obs_rdy, 0);
        chk("lu.bubble", bus.out_valid, 0);
        step(s, "lu.accept");
        chk("lu.acc_valid", bus.out_valid, 1);
        chk("lu.acc_pc", bus.out_pc, 32'h24);

        // bypass on capture and on hold
        s = idle();
        s.valid = 1;
        s.rs1 = 7;
        s.rd1 = 32'h1;
        s.wb_we = 1;
        s.wb_rd = 7;
        s.wb_data = 32'hDEADBEEF;
        step(s, "byp.in");
        chk("byp.rd1", bus.out_rd1, 32'hDEADBEEF);
        s.rs1 = 0;
        s.wb_rd = 0;
        s.rd1 = 32'h1234;
        step(s, "byp.x0");
        chk("byp.x0_rd1", bus.out_rd1, 32'h1234);
        s = idle();
        s.valid = 1;
        s.rs2 = 3;
        s.rd2 = 32'h99;
        step(s, "byp.ld");
        s = idle();
        s.out_ready = 0;
        s.wb_we = 1;
        s.wb_rd = 3;
        s.wb_data = 32'h55;
        step(s, "byp.hold");
        chk("byp.hold_rd2", bus.out_rd2, 32'h55);

        // flush with incoming bundle and stalled consumer
        s = idle();
        s.valid = 1;
        s.pc = 32'h40;
        s.out_ready = 0;
        s.flush = 1;
        step(s, "fl");
        chk("fl.in_ready", obs_rdy, 0);
        chk("fl.out_valid", bus.out_valid, 0);
        step(idle(), "fl.after");
        chk("fl.not_captured", bus.out_valid, 0);

        // reset mid-stream with a full slot
        s = idle();
        s.valid = 1;
        s.pc = 32'h80;
        step(s, "mr.load");
        async_rst("mr");
        s = idle();
        s.valid = 1;
        s.pc = 32'h84;
        step(s, "mr.first");
        chk("mr.first_pc", bus.out_pc, 32'h84);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) async_rst("r.rst");
            step(rnd(), "r");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32: data path width of PC, operand and immediate fields.
REQ-002 Parameter CTRL_W, default 12: width of the opaque control bundle from the control unit.
REQ-003 Parameter RA_W, default 5: register address width.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst  in  1: reset, asynchronous, active-high.
REQ-006 in_valid  in  1: decode-side bundle valid.
REQ-007 in_ready  out  1: stage can accept the decode-side bundle.
REQ-008 in_pc, in_rd1, in_rd2, in_imm  in  XLEN each: PC, register-file read data for rs1 and rs2, sign-extended immediate.
REQ-009 in_ctrl  in  CTRL_W: control bundle.
REQ-010 in_rs1, in_rs2, in_rd  in  RA_W each: source and destination register addresses.
REQ-011 in_mem_read  in  1: instruction is a load.
REQ-012 wb_we  in  1, wb_rd  in  RA_W, wb_data  in  XLEN: writeback port, used for bypass.
REQ-013 flush  in  1: kill the stage contents and any incoming bundle.
REQ-014 out_valid  out  1, out_ready  in  1: execute-side handshake.
REQ-015 out_pc, out_rd1, out_rd2, out_imm  out  XLEN; out_ctrl  out  CTRL_W; out_rs1, out_rs2, out_rd  out  RA_W; out_mem_read  out  1: registered bundle.
REQ-016 hazard_stall  out  1: load-use hazard detected this cycle.

Function
REQ-017 The stage SHALL be one register slot; out_valid SHALL be its occupancy flag.
REQ-018 hazard_stall SHALL equal in_valid & out_valid & out_mem_read & (out_rd != 0) & (out_rd == in_rs1 | out_rd == in_rs2), combinationally.
REQ-019 in_ready SHALL equal (!out_valid | out_ready) & !hazard_stall & !flush.
REQ-020 Accept SHALL be in_valid & in_ready; on accept, all out_* payload fields SHALL load from in_* at the next edge and out_valid SHALL become 1.
REQ-021 If out_valid & out_ready and no accept, out_valid SHALL become 0 at the next edge (bubble; includes the hazard case).
REQ-022 If neither accept nor output transfer, all outputs SHALL hold, except as per REQ-024.
REQ-023 Bypass on load: if wb_we & wb_rd != 0 & wb_rd == in_rs1, out_rd1 SHALL load wb_data instead of in_rd1; likewise rs2/out_rd2; both may apply in one cycle.
REQ-024 Bypass on hold: while out_valid is 1 and the slot holds, if wb_we & wb_rd != 0 & wb_rd == out_rs1 (out_rs2), out_rd1 (out_rd2) SHALL load wb_data.
REQ-025 Register 0 SHALL never be bypassed nor trigger a hazard.
REQ-026 flush SHALL clear out_valid at the next edge regardless of out_ready or in_valid; payload fields are don't-care after flush.
REQ-027 Priority SHALL be rst > flush > accept > drain > hold.
REQ-028 Latency in_valid-accept to out_valid SHALL be exactly one cycle; full throughput (one bundle per cycle) SHALL be sustained when out_ready stays 1 and no hazard.
REQ-029 out_* SHALL be driven only from registers; no combinational in_* -> out_* path.

Reset
REQ-030 While rst is 1, out_valid, out_mem_read and all out_* fields SHALL be 0 immediately, without waiting for clk.
REQ-031 After rst falls, the stage SHALL accept on the first rising edge with in_valid & in_ready.
REQ-032 rst asserted with the slot full SHALL discard the bundle; no transfer is reported.

Verification
REQ-033 Reset mid-stream: rst pulse between edges while out_valid=1 -> out_valid=0 and out_pc=0 before the next edge.
REQ-034 Back-to-back: in_valid=1 for 4 cycles, pc 0x0/0x4/0x8/0xC, out_ready=1 -> out_pc follows one cycle later, out_valid continuously 1.
REQ-035 Backpressure: slot full pc 0x10, out_ready=0 for 3 cycles -> in_ready=0, out_pc stays 0x10; out_ready=1 -> next bundle loads.
REQ-036 Load-use: out_mem_read=1, out_rd=5; incoming in_rs2=5 -> hazard_stall=1, in_ready=0, one bubble (out_valid=0) then the bundle is accepted.
REQ-037 Bypass: in_rs1=7, wb_we=1, wb_rd=7, wb_data=0xDEADBEEF, in_rd1=0x1 -> out_rd1=0xDEADBEEF; with wb_rd=0 and in_rs1=0 -> out_rd1=in_rd1; held slot out_rs2=3 and wb_rd=3, wb_data=0x55 -> out_rd2=0x55.
REQ-038 Flush: slot full, flush=1 with in_valid=1 and out_ready=0 -> in_ready=0, out_valid=0 next edge, incoming bundle not captured.
